cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the Common Data Bus (CDB) among the functional-unit groups of the Tomasulo core: adders, multipliers, load buffers and one spare.
- Each unit raises CDB_rts when a result is ready. The arbiter grants one unit per cycle via a one-hot CDB_xmit, using round-robin order.
- It captures the granted unit's result and broadcasts it, registered, to the reservation stations and the register file.

Parameters:
- NUM_UNITS, 4, number of requesting units; legal range 2..8.
- DATA_W, 32, width of the CDB data word.
- TAG_W, 6, width of the reservation-station source tag.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- unit_rts  input  NUM_UNITS  per-unit request-to-send.
- unit_data  input  NUM_UNITS*DATA_W  per-unit result; unit i occupies bits [i*DATA_W +: DATA_W].
- unit_source  input  NUM_UNITS*TAG_W  per-unit source RS tag, packed the same way.
- unit_write  input  NUM_UNITS  per-unit "driving valid result" strobe.
- CDB_xmit  output  NUM_UNITS  one-hot grant, registered.
- CDB_data  output  DATA_W  broadcast result, registered.
- CDB_source  output  TAG_W  broadcast tag, registered.
- CDB_write  output  1  broadcast valid, registered, one cycle per result.
- grant_id  output  3  index of the unit currently granted; meaningful only while CDB_xmit != 0.
- error  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, reset_n=0), all outputs and state go to:
  - CDB_xmit=0, CDB_data=0, CDB_source=0, CDB_write=0, grant_id=0, error=0.
  - Round-robin pointer rr_ptr=0; FSM in IDLE.
- FSM states:
  - IDLE: no grant outstanding. If eligible requests are non-empty, the winner is the first index at or after rr_ptr, with modulo-NUM_UNITS wrap. Next state GRANT with CDB_xmit[winner]=1, grant_id=winner, rr_ptr=(winner+1) mod NUM_UNITS. Otherwise stay IDLE.
  - GRANT: CDB_xmit stays high for exactly this one cycle.
    - If unit_write[grant_id]=1, capture unit_data and unit_source for grant_id. Next cycle: CDB_write=1, CDB_data/CDB_source hold the captured values.
    - If unit_write[grant_id]=0, set error=1 and do not broadcast.
    - Arbitrate again in the same cycle with the granted unit masked out of eligibility. On a hit, go to GRANT with the new winner (back-to-back grants, one per cycle). On a miss, go to IDLE.
- Eligibility: unit_rts[i]=1 and i is not the unit granted in the current cycle. A unit still holding rts after its grant may win again one cycle later.
- Latency:
  - Request sampled at edge t gives CDB_xmit high during cycle t+1.
  - The unit drives unit_write/data in cycle t+1; CDB_write is high during cycle t+2.
  - Sustained throughput is one broadcast per cycle.
- CDB_write deasserts automatically after one cycle unless another capture occurred.
- CDB_data/CDB_source hold their last value when CDB_write=0.
- Spurious write: unit_write[i]=1 with CDB_xmit[i]=0 sets error=1. The data is ignored and the grant is unaffected.
- error is cleared only by reset.
- Simultaneous requests are resolved purely by rr_ptr. No unit waits more than NUM_UNITS-1 grants.
- Reset asserted mid-GRANT: the grant and pending broadcast are dropped immediately. After release, the FSM restarts in IDLE with rr_ptr=0.
- Out-of-range grant_id values never occur.

Optional Feature:
- Macro: CDB_BUSY_CNT_EN.
- When defined:
  - Adds output busy_cnt (32 bits), reset to 0.
  - busy_cnt increments by 1 on every cycle with CDB_write=1 and saturates at 0xFFFFFFFF.
  - Adds output conflict_cnt (16 bits), reset to 0, saturating. It increments on every cycle where two or more eligible requests exist and at least one is not granted.
- When undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- Single request: unit_rts=4'b0001, then unit 0 drives write with data 10 and tag 6'd1 on xmit. Required: CDB_xmit=0001 one cycle after the request; the cycle after that, CDB_write=1, CDB_data=10, CDB_source=1; error=0.
- Contention: unit_rts=4'b1111 held, every unit writing on its own xmit. Required grant order 0,1,2,3,0, with one CDB_write per cycle after a two-cycle startup.
- Wrap and fairness: rr_ptr left at 3 after a unit-2 grant, then unit_rts=4'b1001. Required: unit 3 granted first, then unit 0.
- Missing write: grant unit 1 while it holds unit_write=0. Required: error=1 the next cycle, CDB_write stays 0, and the FSM continues to serve unit 2's pending request.
- Spurious write: unit_write[2]=1 while CDB_xmit=0001. Required: error=1; the broadcast carries unit 0's data only.
- Reset mid-grant: drop reset_n during a GRANT cycle. Required: all outputs 0 immediately; after release with unit_rts=4'b0010, unit 1 is granted. With CDB_BUSY_CNT_EN defined, busy_cnt reads 0 after reset and 3 after three broadcasts.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Unit-side request/result bus and CDB broadcast bundle for the
//               CDB arbiter. Optional counters exist with CDB_BUSY_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cdb_arbiter_if #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6
);
    logic [NUM_UNITS-1:0]        unit_rts;
    logic [NUM_UNITS*DATA_W-1:0] unit_data;
    logic [NUM_UNITS*TAG_W-1:0]  unit_source;
    logic [NUM_UNITS-1:0]        unit_write;

    logic [NUM_UNITS-1:0]        CDB_xmit;
    logic [DATA_W-1:0]           CDB_data;
    logic [TAG_W-1:0]            CDB_source;
    logic                        CDB_write;
    logic [2:0]                  grant_id;
    logic                        error;
`ifdef CDB_BUSY_CNT_EN
    logic [31:0]                 busy_cnt;
    logic [15:0]                 conflict_cnt;

    modport master (
        input  unit_rts, unit_data, unit_source, unit_write,
        output CDB_xmit, CDB_data, CDB_source, CDB_write, grant_id, error,
        output busy_cnt, conflict_cnt
    );
    modport slave (
        output unit_rts, unit_data, unit_source, unit_write,
        input  CDB_xmit, CDB_data, CDB_source, CDB_write, grant_id, error,
        input  busy_cnt, conflict_cnt
    );
`else
    modport master (
        input  unit_rts, unit_data, unit_source, unit_write,
        output CDB_xmit, CDB_data, CDB_source, CDB_write, grant_id, error
    );
    modport slave (
        output unit_rts, unit_data, unit_source, unit_write,
        input  CDB_xmit, CDB_data, CDB_source, CDB_write, grant_id, error
    );
`endif
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin Common Data Bus arbiter with registered broadcast.
//               Optional busy/conflict counters enabled by CDB_BUSY_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6
) (
    input  wire logic     clock,
    input  wire logic     reset_n,
    cdb_arbiter_if.master bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_rr_ptr;
    logic [NUM_UNITS-1:0]   r_xmit;
    logic [DATA_W-1:0]      r_data;
    logic [TAG_W-1:0]       r_source;
    logic                   r_write;
    logic [2:0]             r_grant_id;
    logic                   r_error;

    logic [NUM_UNITS-1:0]   w_eligible;
    logic [2*NUM_UNITS-1:0] w_dbl;
    logic [NUM_UNITS-1:0]   w_rot;
    logic [2:0]             w_off;
    logic [3:0]             w_sum;
    logic [2:0]             w_winner;
    logic [2:0]             w_next_rr;
    logic                   w_hit;
    logic [NUM_UNITS-1:0]   w_grant_vec;
    logic [DATA_W-1:0]      w_cap_data;
    logic [TAG_W-1:0]       w_cap_source;
    logic                   w_gnt_write;
    logic                   w_spurious;

    // The unit holding the grant this cycle is masked out of the next pick.
    assign w_eligible = bus.unit_rts & ~r_xmit;
    assign w_hit      = |w_eligible;
    assign w_dbl      = {w_eligible, w_eligible};
    assign w_rot      = NUM_UNITS'(w_dbl >> r_rr_ptr);

    always_comb begin
        w_off = 3'd0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 3'(k);
            end
        end
    end

    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_winner    = (w_sum >= 4'(NUM_UNITS)) ? 3'(w_sum - 4'(NUM_UNITS)) : w_sum[2:0];
    assign w_next_rr   = (w_winner == 3'(NUM_UNITS - 1)) ? 3'd0 : w_winner + 3'd1;
    assign w_grant_vec = w_hit ? (NUM_UNITS'(1) << w_winner) : '0;

    // r_xmit is one-hot, so an AND-OR mux selects the granted lane.
    always_comb begin
        w_cap_data   = '0;
        w_cap_source = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (r_xmit[i]) begin
                w_cap_data   = w_cap_data   | bus.unit_data[i*DATA_W +: DATA_W];
                w_cap_source = w_cap_source | bus.unit_source[i*TAG_W +: TAG_W];
            end
        end
    end

    assign w_gnt_write = |(bus.unit_write & r_xmit);
    assign w_spurious  = |(bus.unit_write & ~r_xmit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 3'd0;
            r_xmit     <= '0;
            r_data     <= '0;
            r_source   <= '0;
            r_write    <= 1'b0;
            r_grant_id <= 3'd0;
            r_error    <= 1'b0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                GRANT: begin
                    if (w_gnt_write) begin
                        r_write  <= 1'b1;
                        r_data   <= w_cap_data;
                        r_source <= w_cap_source;
                    end else begin
                        r_error  <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_spurious) begin
                r_error <= 1'b1;
            end
            r_xmit <= w_grant_vec;
            if (w_hit) begin
                r_state    <= GRANT;
                r_grant_id <= w_winner;
                r_rr_ptr   <= w_next_rr;
            end else begin
                r_state    <= IDLE;
            end
        end
    end

    assign bus.CDB_xmit   = r_xmit;
    assign bus.CDB_data   = r_data;
    assign bus.CDB_source = r_source;
    assign bus.CDB_write  = r_write;
    assign bus.grant_id   = r_grant_id;
    assign bus.error      = r_error;

`ifdef CDB_BUSY_CNT_EN
    logic [31:0] r_busy_cnt;
    logic [15:0] r_conflict_cnt;
    logic        w_multi;

    // Non-zero when more than one bit is set: at least one request loses.
    assign w_multi = |(w_eligible & (w_eligible - NUM_UNITS'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy_cnt     <= 32'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            if (r_write && (r_busy_cnt != 32'hFFFF_FFFF)) begin
                r_busy_cnt <= r_busy_cnt + 32'd1;
            end
            if (w_multi && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign bus.busy_cnt     = r_busy_cnt;
    assign bus.conflict_cnt = r_conflict_cnt;
`endif

endmodule

`default_nettype wire
